// File: rtl/inst_fetcher.sv
// Byte-serial instruction fetcher: issues four byte reads per word, assembles
// them little-endian and buffers complete words in a circular queue for decode.
module inst_fetcher #(
    parameter int          QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [7:0]  mem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(QUEUE_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [31:0]        fetch_pc;
    logic [1:0]         issue_idx;
    logic [1:0]         collect_idx;
    logic [23:0]        partial;
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count;
    logic               drop;
    logic [31:0]        q_inst [QUEUE_DEPTH];
    logic [31:0]        q_pc   [QUEUE_DEPTH];

    logic               flush;
    logic               capture;
    logic               word_done;
    logic               pop;

    assign flush      = rdy_in && redirect_valid;
    // Bytes are only ever in flight outside IDLE, so gating on IDLE also
    // discards a stale response arriving right after reset.
    assign capture    = mem_rvalid && !drop && (state != IDLE);
    assign word_done  = capture && (collect_idx == 2'd3);
    assign inst_valid = (count != '0);
    assign pop        = inst_valid && inst_ready && rdy_in;
    assign inst       = inst_valid ? q_inst[head] : 32'h0;
    assign inst_pc    = inst_valid ? q_pc[head]   : 32'h0;

    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        mem_addr  = fetch_pc + 32'(issue_idx);
        case (state)
            IDLE: begin
                if (count < DEPTH_C) state_nxt = FETCH;
            end
            FETCH: begin
                mem_req = 1'b1;
                if (mem_gnt && issue_idx == 2'd3) state_nxt = DRAIN;
            end
            DRAIN: begin
                // The completing word is not yet counted, so reserve its slot
                // before starting the next one in the same cycle.
                mem_addr = fetch_pc + 32'd4;
                if (word_done) begin
                    if (count < LAST_C) begin
                        mem_req   = 1'b1;
                        state_nxt = FETCH;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (!rdy_in) begin
            mem_req   = 1'b0;
            state_nxt = (state == DRAIN && word_done) ? IDLE : state;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            issue_idx   <= 2'd0;
            collect_idx <= 2'd0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            drop        <= 1'b0;
        end else if (flush) begin
            state       <= FETCH;
            fetch_pc    <= redirect_pc;
            issue_idx   <= 2'd0;
            collect_idx <= 2'd0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            drop        <= 1'b1;
        end else begin
            state <= state_nxt;
            drop  <= 1'b0;
            if (mem_req && mem_gnt) issue_idx <= issue_idx + 2'd1;
            if (capture) collect_idx <= collect_idx + 2'd1;
            if (word_done) begin
                fetch_pc <= fetch_pc + 32'd4;
                tail     <= tail + PTR_W'(1);
            end
            if (pop) head <= head + PTR_W'(1);
            if (word_done && !pop) begin
                count <= count + CNT_W'(1);
            end else if (!word_done && pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (capture && !word_done) begin
            case (collect_idx)
                2'd0:    partial[7:0]   <= mem_rdata;
                2'd1:    partial[15:8]  <= mem_rdata;
                default: partial[23:16] <= mem_rdata;
            endcase
        end
        if (word_done && !flush) begin
            q_inst[tail] <= {mem_rdata, partial};
            q_pc[tail]   <= fetch_pc;
        end
    end

endmodule

// File: tb/tb_inst_fetcher.sv
// Bench for inst_fetcher: byte memory responder, request-address model and a
// scoreboard of expected (pc, word) pairs popped on every decoder handshake.
module tb_inst_fetcher;

    localparam int          QD  = 4;
    localparam logic [31:0] RPC = 32'hFFFF_FFFC;

    logic        clk;
    logic        rst_in;
    logic        rdy_in;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [7:0]  mem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    int errors = 0;
    int checks = 0;
    int gnt_mode = 0;

    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_inst_q[$];

    inst_fetcher #(.QUEUE_DEPTH(QD), .RESET_PC(RPC)) dut (
        .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'd0:   return 8'h93;
            32'd1:   return 8'h00;
            32'd2:   return 8'h50;
            32'd3:   return 8'h00;
            default: return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A ^ {a[1:0], 6'b0};
        endcase
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        return {mem_byte(pc + 32'd3), mem_byte(pc + 32'd2),
                mem_byte(pc + 32'd1), mem_byte(pc)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Sequential fetch from pc: the decoder must see these words in order.
    task automatic load_exp(input logic [31:0] pc);
        exp_pc_q.delete();
        exp_inst_q.delete();
        for (int i = 0; i < 128; i++) begin
            exp_pc_q.push_back(pc + 32'(4 * i));
            exp_inst_q.push_back(mem_word(pc + 32'(4 * i)));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        load_exp(pc);
        step();
        redirect_valid = 1'b0;
    endtask

    // Memory: every granted request returns its byte exactly one cycle later.
    initial begin
        logic        g_q;
        logic [31:0] a_q;
        mem_rvalid = 1'b0;
        mem_rdata  = 8'h0;
        forever begin
            @(negedge clk);
            g_q = (mem_req === 1'b1) && (mem_gnt === 1'b1);
            a_q = mem_addr;
            @(posedge clk);
            #1;
            mem_rvalid = g_q;
            mem_rdata  = mem_byte(a_q);
        end
    end

    initial begin
        mem_gnt = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (gnt_mode)
                0:       mem_gnt = 1'b1;
                1:       mem_gnt = 1'($urandom % 2);
                default: mem_gnt = !mem_gnt;
            endcase
        end
    end

    // Monitor: address model, stability while stalled, scoreboard pops.
    initial begin
        logic [31:0] exp_addr;
        logic        prev_hold;
        logic [31:0] prev_inst;
        logic [31:0] prev_pc;
        exp_addr  = RPC;
        prev_hold = 1'b0;
        prev_inst = 32'h0;
        prev_pc   = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst_in) begin
                exp_addr  = RPC;
                prev_hold = 1'b0;
            end else if (redirect_valid && rdy_in) begin
                exp_addr  = redirect_pc;
                prev_hold = 1'b0;
            end else begin
                if (!rdy_in) chk("req_while_not_rdy", 32'(mem_req), 32'd0);
                if (prev_hold) begin
                    chk("stall_valid", 32'(inst_valid), 32'd1);
                    chk("stall_inst", inst, prev_inst);
                    chk("stall_pc", inst_pc, prev_pc);
                end
                if (mem_req) begin
                    chk("mem_addr", mem_addr, exp_addr);
                    if (mem_gnt) exp_addr = exp_addr + 32'd1;
                end
                if (inst_valid && inst_ready && rdy_in) begin
                    if (exp_pc_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_empty: got pc %h with no expected entry", inst_pc);
                    end else begin
                        chk("sb_pc", inst_pc, exp_pc_q.pop_front());
                        chk("sb_inst", inst, exp_inst_q.pop_front());
                    end
                end
                prev_hold = inst_valid && !(inst_ready && rdy_in);
                prev_inst = inst;
                prev_pc   = inst_pc;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_addr"}, mem_addr, RPC);
        chk({tag, "_valid"}, 32'(inst_valid), 32'd0);
        chk({tag, "_inst"}, inst, 32'd0);
        chk({tag, "_pc"}, inst_pc, 32'd0);
    endtask

    task automatic wait_grant(input logic [31:0] a, input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (mem_req && mem_gnt && mem_addr == a) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: grant at %h not seen, required within 40 cycles", name, a);
        end
    endtask

    initial begin
        int lat;
        int grants;
        bit seen;
        rst_in = 1'b0;
        rdy_in = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        inst_ready = 1'b1;
        load_exp(RPC);

        step();
        step();
        @(negedge clk);
        check_reset_outputs("reset");
        step();
        rst_in = 1'b1;
        @(negedge clk);
        chk("idle_after_release", 32'(mem_req), 32'd0);
        @(negedge clk);
        chk("first_req", 32'(mem_req), 32'd1);
        chk("first_addr", mem_addr, RPC);

        // Byte-0 grant to first inst_valid, empty queue, back-to-back grants.
        lat = 0;
        seen = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk);
            if (inst_valid) begin
                lat = k;
                seen = 1'b1;
            end
        end
        chk("latency", 32'(lat), 32'd5);
        chk("wrap_first_pc", inst_pc, RPC);
        step();
        repeat (12) step();

        // Backpressure: queue fills to exactly QD words, then requests stop.
        inst_ready = 1'b0;
        do_redirect(32'h0);
        grants = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (mem_req && mem_gnt) grants++;
        end
        chk("bp_grants", 32'(grants), 32'(4 * QD));
        chk("bp_req_off", 32'(mem_req), 32'd0);
        chk("bp_head_pc", inst_pc, 32'h0);
        chk("bp_head_inst", inst, 32'h0050_0093);
        step();
        inst_ready = 1'b1;
        repeat (30) step();

        // Redirect while the second word is mid-issue.
        inst_ready = 1'b0;
        do_redirect(32'h40);
        wait_grant(32'h45, "mid_wait");
        chk("mid_valid_before", 32'(inst_valid), 32'd1);
        step();
        do_redirect(32'h100);
        @(negedge clk);
        chk("mid_flushed", 32'(inst_valid), 32'd0);
        chk("mid_req", 32'(mem_req), 32'd1);
        chk("mid_addr", mem_addr, 32'h100);
        step();
        inst_ready = 1'b1;
        repeat (20) step();

        // Alternating grants.
        gnt_mode = 2;
        do_redirect(32'h200);
        repeat (40) step();
        gnt_mode = 0;
        step();

        // Reset mid-word, after byte 1 has returned.
        do_redirect(32'h300);
        wait_grant(32'h301, "rst_wait");
        step();
        step();
        rst_in = 1'b0;
        load_exp(RPC);
        step();
        @(negedge clk);
        check_reset_outputs("midrst");
        step();
        rst_in = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 5 && !seen; k++) begin
            @(negedge clk);
            if (mem_req) begin
                seen = 1'b1;
                chk("refetch_addr", mem_addr, RPC);
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL refetch_req: no request, required within 5 cycles");
        end
        step();
        repeat (20) step();

        // Randomized traffic with stalls, random grants and redirects.
        gnt_mode = 1;
        for (int i = 0; i < 500; i++) begin
            inst_ready = ($urandom % 3) != 0;
            rdy_in = ($urandom % 8) != 0;
            redirect_valid = 1'b0;
            if (rdy_in && ($urandom % 50) == 0) begin
                if (($urandom % 4) == 0) redirect_pc = 32'hFFFF_FFF0;
                else redirect_pc = $urandom & 32'h0000_FFFC;
                redirect_valid = 1'b1;
                load_exp(redirect_pc);
            end
            step();
        end
        redirect_valid = 1'b0;
        rdy_in = 1'b1;
        inst_ready = 1'b1;
        gnt_mode = 0;
        repeat (60) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_fetcher.md
INST_FETCHER -- requirements
Module: inst_fetcher

Interface
REQ-001 Parameter QUEUE_DEPTH, default 4, number of instruction-queue entries; the value SHALL be a power of two and at least 2.
REQ-002 Parameter RESET_PC, default 32'h0, first fetch address after reset.
REQ-003 clk_in  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 rst_in  input  1  reset: synchronous, active-low.
REQ-005 rdy_in  input  1  global enable; when 0, all state SHALL hold and mem_req SHALL be 0.
REQ-006 mem_req  output  1  byte-read request.
REQ-007 mem_addr  output  32  byte address of the request.
REQ-008 mem_gnt  input  1  request accepted in the current cycle.
REQ-009 mem_rvalid  input  1  mem_rdata is valid; asserted exactly one cycle after each granted request.
REQ-010 mem_rdata  input  8  returned byte.
REQ-011 redirect_valid  input  1  flush request and new PC (branch mispredict, jump).
REQ-012 redirect_pc  input  32  new fetch PC; bits [1:0] are zero.
REQ-013 inst_valid  output  1  the head queue entry is valid for the decoder.
REQ-014 inst_ready  input  1  the decoder accepts the head entry.
REQ-015 inst  output  32  raw instruction word, little-endian assembled.
REQ-016 inst_pc  output  32  address of inst.

Function
REQ-017 The block SHALL keep fetch_pc, a byte index issue_idx (0..3), a collect_idx (0..3), a 24-bit partial-word buffer, and a circular queue with head/tail pointers and a count.
REQ-018 FSM states: IDLE, FETCH, DRAIN.
  - IDLE -> FETCH when free queue slots > 0.
  - FETCH -> DRAIN after the byte-3 grant.
  - DRAIN -> FETCH when the word completes and a slot is still free.
  - DRAIN -> IDLE when the word completes and the queue is full.
REQ-019 In FETCH, mem_req SHALL be 1 and mem_addr SHALL be fetch_pc + issue_idx; issue_idx SHALL advance only on mem_gnt.
REQ-020 Each byte with mem_rvalid SHALL be stored at bits [8*collect_idx+7 : 8*collect_idx] of the word, and collect_idx SHALL advance.
REQ-021 On byte 3 arrival, {mem_rdata, partial[23:0]} SHALL be written at tail together with fetch_pc.
  - fetch_pc SHALL advance by 4.
  - tail SHALL advance modulo QUEUE_DEPTH.
  - Latency from the byte-0 grant to inst_valid is 5 cycles when the queue was empty and grants are back-to-back.
REQ-022 A new word's byte-0 request SHALL issue only if count + (word in flight ? 1 : 0) < QUEUE_DEPTH.
  - The queue therefore never overflows.
  - With gnt held at 1, byte 0 of the next word SHALL issue in the same cycle as byte 3 of the current word returns (no bubble).
REQ-023 Handshake:
  - inst/inst_pc SHALL come from head whenever inst_valid = 1, and inst_valid = (count != 0).
  - A pop SHALL occur on inst_valid & inst_ready.
  - A simultaneous push and pop SHALL leave count unchanged.
  - inst and inst_pc SHALL remain stable while inst_valid & !inst_ready.
REQ-024 redirect_valid (rdy_in = 1) SHALL take effect in one cycle and SHALL take priority over pushes, pops and grants in that cycle:
  - count, head, tail, issue_idx and collect_idx SHALL be set to 0.
  - fetch_pc SHALL be set to redirect_pc.
  - the state SHALL go to FETCH.
REQ-025 A byte returning in the cycle after a redirect (a response to a pre-redirect grant) SHALL be discarded via a one-cycle drop flag.
REQ-026 The pop in a redirect cycle SHALL NOT be counted: inst_valid is still 1 in that cycle, but the flushed entry is discarded.
REQ-027 fetch_pc SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 -> 0).
REQ-028 When rdy_in = 0 with a byte in flight, the returning byte SHALL still be captured so that no data is lost; all other state SHALL hold.

Reset
REQ-029 On a clock edge with rst_in = 0 (rdy_in ignored), the block SHALL enter the following state:
  - state = IDLE; fetch_pc = RESET_PC.
  - count, head, tail, issue_idx, collect_idx and the drop flag = 0.
  - mem_req = 0, mem_addr = RESET_PC, inst_valid = 0, inst = 0, inst_pc = 0.
REQ-030 Reset asserted mid-word SHALL abandon the partial word, and any mem_rvalid in the following cycle SHALL be ignored.
REQ-031 The first request after reset release SHALL issue in the second cycle (IDLE -> FETCH).

Verification
REQ-032 Basic fetch: memory holds 0x00500093 at address 0, gnt tied to 1, inst_ready = 1 -> mem_addr sequence 0,1,2,3; inst = 32'h00500093, inst_pc = 0; the next word has inst_pc = 4.
REQ-033 Backpressure: inst_ready = 0 for 20 cycles -> exactly QUEUE_DEPTH words are fetched (inst_pc values 0, 4, 8, 12), then mem_req = 0; release -> the words pop in order, with no loss or duplication.
REQ-034 Redirect mid-word: redirect_valid with redirect_pc = 0x100 while issue_idx = 2 -> the in-flight byte is dropped, the queue is empty the next cycle, and the next requests are 0x100..0x103.
REQ-035 Grant stalls: mem_gnt toggles 1,0,1,0 -> the assembled word is correct and mem_addr is held during gnt = 0.
REQ-036 Wrap: RESET_PC = 32'hFFFF_FFFC -> first inst_pc = FFFF_FFFC, second inst_pc = 0.
REQ-037 Reset mid-operation: assert rst_in low after byte 1 returns -> all outputs go to their reset values the next cycle, and refetch starts at RESET_PC.
